// File: rtl/uart_tx_dev.sv
// rtl/uart_tx_dev.sv - memory-mapped 8N1 UART transmitter with TX FIFO and drain interrupt
module uart_tx_dev #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        txd,
  output logic        IRQ
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [1:0]    ctrl;
  logic [15:0]   divisor;
  logic [7:0]    last_byte;
  state_t        state;
  logic [7:0]    shreg;
  logic [15:0]   reload;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;

  logic [1:0] sel;
  logic       push_req, push, pop, empty, full, bit_end, busy;
  logic [4:0] count_ext;
  logic       unused;

  assign sel       = Addr[3:2];
  assign push_req  = WE && (sel == 2'd0);
  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign busy      = (state != IDLE);
  assign bit_end   = (baud_cnt == reload - 16'd1);
  assign count_ext = 5'(count);
  assign unused    = ^{Addr[31:4], Din[31:16]};

  // A frame may start from IDLE or directly at the end of a stop bit.
  assign pop  = ctrl[0] && !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Din[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      ctrl      <= 2'b00;
      divisor   <= DIV_RESET;
      last_byte <= 8'h00;
      state     <= IDLE;
      shreg     <= 8'h00;
      reload    <= DIV_RESET;
      baud_cnt  <= 16'd0;
      bit_idx   <= 3'd0;
      txd       <= 1'b1;
      IRQ       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(1);
        last_byte <= Din[7:0];
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      if (push_req && !push)           overflow <= 1'b1;
      else if (WE && (sel == 2'd1))    overflow <= 1'b0;
      if (WE && (sel == 2'd2))         ctrl <= Din[1:0];
      if (WE && (sel == 2'd3))         divisor <= (Din[15:0] == 16'd0) ? 16'd1 : Din[15:0];

      IRQ <= ctrl[1] && empty && (state == IDLE);

      case (state)
        IDLE: txd <= 1'b1;
        START: begin
          if (bit_end) begin
            state    <= DATA;
            baud_cnt <= 16'd0;
            txd      <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) state <= IDLE;
          else         baud_cnt <= baud_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase

      // Frame start overrides the per-state updates above.
      if (pop) begin
        state    <= START;
        shreg    <= mem[rd_ptr];
        reload   <= divisor;
        baud_cnt <= 16'd0;
        bit_idx  <= 3'd0;
        txd      <= 1'b0;
      end
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (sel)
      2'd0: Dout = {24'd0, last_byte};
      2'd1: Dout = {23'd0, count_ext, overflow, empty, full, busy};
      2'd2: Dout = {30'd0, ctrl};
      2'd3: Dout = {16'd0, divisor};
      default: Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb/tb_uart_tx_dev.sv - directed self-checking bench for uart_tx_dev
module tb_uart_tx_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:2] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        txd, IRQ;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  typedef struct {
    logic [1:0]  a;
    logic        we;
    logic [31:0] din;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  uart_tx_dev #(.FIFO_DEPTH(8), .DIV_RESET(16'd16)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .txd(txd), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = {28'd0, a};
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    Addr = {28'd0, a};
    #1;
    chk(name, Dout, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] a, input logic we, input logic [31:0] din,
                              input logic [31:0] exp, input string name);
    vec_t v;
    v.a = a; v.we = we; v.din = din; v.exp = exp; v.name = name;
    return v;
  endfunction

  // Expected txd per clock for one 8N1 frame at the given bit length.
  function automatic void add_frame(input logic [7:0] b, input int div);
    for (int j = 0; j < 10; j++) begin
      bit v;
      v = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
      for (int c = 0; c < div; c++) exp_q.push_back(v);
    end
  endfunction

  task automatic check_txd(input string name, input bit chk_busy);
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      bit e;
      e = exp_q.pop_front();
      @(posedge clk);
      #1;
      k++;
      chk($sformatf("%s txd[%0d]", name, k), {31'd0, txd}, {31'd0, e});
      if (chk_busy) chk($sformatf("%s busy[%0d]", name, k), {31'd0, Dout[0]}, 32'd1);
    end
  endtask

  initial begin
    vecs[0] = mk(2'd1, 1'b0, 32'h0,          32'h4,    "rst_status");
    vecs[1] = mk(2'd3, 1'b0, 32'h0,          32'h10,   "rst_divisor");
    vecs[2] = mk(2'd2, 1'b0, 32'h0,          32'h0,    "rst_ctrl");
    vecs[3] = mk(2'd0, 1'b0, 32'h0,          32'h0,    "rst_data");
    vecs[4] = mk(2'd2, 1'b1, 32'hFFFF_FFFF,  32'h3,    "ctrl_mask");
    vecs[5] = mk(2'd2, 1'b1, 32'h0,          32'h0,    "ctrl_clear");
    vecs[6] = mk(2'd3, 1'b1, 32'h0001_2345,  32'h2345, "div_mask");
    vecs[7] = mk(2'd3, 1'b1, 32'h0,          32'h1,    "div_zero");
    vecs[8] = mk(2'd3, 1'b1, 32'h4,          32'h4,    "div_four");
    vecs[9] = mk(2'd1, 1'b0, 32'h0,          32'h4,    "status_idle");

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) wr(vecs[i].a, vecs[i].din);
      rd(vecs[i].a, vecs[i].exp, vecs[i].name);
    end

    // Single byte, DIVISOR=4
    wr(2'd2, 32'h1);
    wr(2'd0, 32'hA5);
    chk("a5_no_early_fall", {31'd0, txd}, 32'd1);
    Addr = 30'd1;
    add_frame(8'hA5, 4);
    check_txd("a5", 1'b1);
    @(posedge clk);
    #1;
    chk("a5_idle_txd", {31'd0, txd}, 32'd1);
    chk("a5_idle_busy", {31'd0, Dout[0]}, 32'd0);
    rd(2'd0, 32'hA5, "a5_last_byte");

    // Back-to-back frames and IRQ, DIVISOR=2
    wr(2'd3, 32'h2);
    wr(2'd2, 32'h2);
    chk("irq_en_lat0", {31'd0, IRQ}, 32'd0);
    @(posedge clk);
    #1;
    chk("irq_en_lat1", {31'd0, IRQ}, 32'd1);
    wr(2'd0, 32'h01);
    chk("irq_push_lat0", {31'd0, IRQ}, 32'd1);
    wr(2'd0, 32'h02);
    chk("irq_push_lat1", {31'd0, IRQ}, 32'd0);
    wr(2'd0, 32'h03);
    wr(2'd2, 32'h3);
    Addr = 30'd1;
    add_frame(8'h01, 2);
    add_frame(8'h02, 2);
    add_frame(8'h03, 2);
    for (int k = 1; k <= 62; k++) begin
      bit e;
      @(posedge clk);
      #1;
      if (k <= 60) begin
        e = exp_q.pop_front();
        chk($sformatf("b2b txd[%0d]", k), {31'd0, txd}, {31'd0, e});
      end
      if (k == 1)  chk("b2b_count_f1", {27'd0, Dout[8:4]}, 32'd2);
      if (k == 21) chk("b2b_count_f2", {27'd0, Dout[8:4]}, 32'd1);
      if (k == 41) chk("b2b_count_f3", {27'd0, Dout[8:4]}, 32'd0);
      if (k == 60 || k == 61) chk($sformatf("b2b_irq_low[%0d]", k), {31'd0, IRQ}, 32'd0);
      if (k == 62) chk("b2b_irq_rise", {31'd0, IRQ}, 32'd1);
    end

    // Overflow with TXEN=0
    wr(2'd2, 32'h0);
    for (int i = 0; i < 9; i++) wr(2'd0, 32'h10 + 32'(i));
    rd(2'd1, 32'h8A, "ovf_status");
    chk("ovf_txd_idle", {31'd0, txd}, 32'd1);
    wr(2'd1, 32'h0);
    rd(2'd1, 32'h82, "ovf_clear");
    wr(2'd3, 32'h0);
    rd(2'd3, 32'h1, "div_zero_reads_one");
    wr(2'd2, 32'h1);
    Addr = 30'd1;
    for (int i = 0; i < 8; i++) add_frame(8'h10 + 8'(i), 1);
    check_txd("ovf_drain", 1'b1);
    @(posedge clk);
    #1;
    chk("ovf_drained_status", Dout, 32'h4);
    chk("ovf_drained_txd", {31'd0, txd}, 32'd1);

    // DIVISOR change mid-frame applies to the next frame only
    wr(2'd0, 32'h5A);
    wr(2'd0, 32'hC3);
    wr(2'd3, 32'h8);
    add_frame(8'h5A, 1);
    add_frame(8'hC3, 8);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    check_txd("divchg", 1'b0);

    // Reset during DATA bit 3 while txd is low
    wr(2'd2, 32'h3);
    wr(2'd0, 32'hF0);
    repeat (35) @(posedge clk);
    #3;
    chk("midrst_pre_txd", {31'd0, txd}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_txd_async", {31'd0, txd}, 32'd1);
    chk("midrst_irq_async", {31'd0, IRQ}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    rd(2'd1, 32'h4,  "midrst_status");
    rd(2'd3, 32'h10, "midrst_divisor");
    rd(2'd2, 32'h0,  "midrst_ctrl");
    rd(2'd0, 32'h0,  "midrst_data");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
